dcache_wb: RTL

Parametrised write-back, write-allocate data cache that replaces the pass-through data path in the per-CPU `caches` wrapper. It sits between the datapath's data-memory port and the memory controller's data channel. It is set-associative, with multi-word blocks and LRU replacement. On halt it flushes every dirty block to memory before asserting `flushed`.

---
 rtl/dcache_wb.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_wb.sv
// Write-back, write-allocate set-associative data cache with LRU replacement and halt-time flush.
// Optional feature macro DCACHE_HITCOUNT_EN: saturating hit counter written to 0x3100 after the flush.
module dcache_wb #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2,
    parameter int CPUID = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int OFFW = $clog2(WORDS);
    localparam int CW   = (OFFW > 0) ? OFFW : 1;
    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - OFFW - IDXW;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, DONE} state_t;

    state_t          state;
    logic            valid [SETS][WAYS];
    logic            dirty [SETS][WAYS];
    logic [TAGW-1:0] tags  [SETS][WAYS];
    logic [31:0]     data  [SETS][WAYS][WORDS];
    logic            lru   [SETS];

    logic [CW-1:0]   cnt;
    logic [IDXW-1:0] idx_r;
    logic [TAGW-1:0] rtag;
    logic            way_r;
    logic            halt_pend;
    logic [IDXW-1:0] fset;
    logic            fway;
`ifdef DCACHE_HITCOUNT_EN
    logic [31:0]     hit_cnt;
    logic            scan_done;
`endif

    logic [CW-1:0]   req_off;
    logic [IDXW-1:0] req_idx;
    logic [TAGW-1:0] req_tag;
    logic [WAYS-1:0] hit_vec;
    logic            hit, hit_way, victim, access;
    logic            word_last, flush_line, flush_adv, scan_last;

    // Rebuilds a memory word address from its tag, set index and word offset.
    function automatic logic [31:0] blk_addr(input logic [TAGW-1:0] t, input logic [IDXW-1:0] i,
                                             input logic [CW-1:0] w);
        return {t, i, {(OFFW + 2){1'b0}}} | (32'(w) << 2);
    endfunction

    assign req_off = CW'(dmemaddr[31:2] & 30'(WORDS - 1));
    assign req_idx = dmemaddr[2 + OFFW +: IDXW];
    assign req_tag = dmemaddr[31 -: TAGW];
    assign access  = dmemREN | dmemWEN;

    // Tag lookup, victim choice and flush-scan bookkeeping.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid[req_idx][w] && (tags[req_idx][w] == req_tag);
        end
        hit        = |hit_vec;
        hit_way    = hit_vec[WAYS-1] && (WAYS == 2);
        victim     = (WAYS == 2) ? lru[req_idx] : 1'b0;
        word_last  = (cnt == LAST);
        flush_line = valid[fset][fway] && dirty[fset][fway];
        flush_adv  = flush_line ? (!dwait && word_last) : 1'b1;
        scan_last  = (fset == IDXW'(SETS - 1)) && (fway == 1'(WAYS - 1));
    end

    // A halt request pre-empts the access, so no hit is reported for it.
    assign dhit     = (state == IDLE) && !halt && access && hit;
    assign dmemload = dhit ? data[req_idx][hit_way][req_off] : 32'h0;
    assign flushed  = (state == DONE);

    // Memory channel driven purely from registered state, hence stable while dwait holds.
    always_comb begin
        dREN   = 1'b0;
        dWEN   = 1'b0;
        daddr  = 32'h0;
        dstore = 32'h0;
        case (state)
            WB: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(tags[idx_r][way_r], idx_r, cnt);
                dstore = data[idx_r][way_r][cnt];
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = blk_addr(rtag, idx_r, cnt);
            end
            FLUSH: begin
`ifdef DCACHE_HITCOUNT_EN
                if (scan_done) begin
                    dWEN   = 1'b1;
                    daddr  = 32'h0000_3100;
                    dstore = hit_cnt;
                end else
`endif
                if (flush_line) begin
                    dWEN   = 1'b1;
                    daddr  = blk_addr(tags[fset][fway], fset, cnt);
                    dstore = data[fset][fway][cnt];
                end else begin
                    dWEN = 1'b0;
                end
            end
            default: dREN = 1'b0;
        endcase
    end

    // Controller FSM plus line-state arrays.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            idx_r     <= '0;
            rtag      <= '0;
            way_r     <= 1'b0;
            halt_pend <= 1'b0;
            fset      <= '0;
            fway      <= 1'b0;
`ifdef DCACHE_HITCOUNT_EN
            hit_cnt   <= 32'h0;
            scan_done <= 1'b0;
`endif
            for (int s = 0; s < SETS; s++) begin
                lru[s] <= 1'b0;
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                end
            end
        end else begin
`ifdef DCACHE_HITCOUNT_EN
            if (dhit && hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
`endif
            case (state)
                IDLE: begin
                    if (halt) begin
                        state <= FLUSH;
                    end else if (access && hit) begin
                        if (dmemWEN) begin
                            data[req_idx][hit_way][req_off] <= dmemstore;
                            dirty[req_idx][hit_way]         <= 1'b1;
                        end
                        lru[req_idx] <= (WAYS == 2) ? ~hit_way : 1'b0;
                    end else if (access) begin
                        idx_r <= req_idx;
                        rtag  <= req_tag;
                        way_r <= victim;
                        cnt   <= '0;
                        state <= (valid[req_idx][victim] && dirty[req_idx][victim]) ? WB : FETCH;
                    end
                end
                WB: begin
                    if (halt) halt_pend <= 1'b1;
                    if (!dwait) begin
                        if (word_last) begin
                            cnt                 <= '0;
                            dirty[idx_r][way_r] <= 1'b0;
                            state               <= FETCH;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (halt) halt_pend <= 1'b1;
                    if (!dwait) begin
                        data[idx_r][way_r][cnt] <= dload;
                        if (word_last) begin
                            cnt                 <= '0;
                            valid[idx_r][way_r] <= 1'b1;
                            dirty[idx_r][way_r] <= 1'b0;
                            tags[idx_r][way_r]  <= rtag;
                            halt_pend           <= 1'b0;
                            state               <= (halt || halt_pend) ? FLUSH : IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
`ifdef DCACHE_HITCOUNT_EN
                    if (scan_done) begin
                        if (!dwait) state <= DONE;
                    end else begin
`endif
                    if (flush_line && !dwait) begin
                        if (word_last) begin
                            cnt               <= '0;
                            dirty[fset][fway] <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    if (flush_adv) begin
                        if (scan_last) begin
`ifdef DCACHE_HITCOUNT_EN
                            scan_done <= 1'b1;
`else
                            state <= DONE;
`endif
                        end else if (WAYS == 2 && fway == 1'b0) begin
                            fway <= 1'b1;
                        end else begin
                            fway <= 1'b0;
                            fset <= fset + 1'b1;
                        end
                    end
`ifdef DCACHE_HITCOUNT_EN
                    end
`endif
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
